// File: rtl/counter_pkg.sv
// Shared types and constants for the up/down modulo counter.
package counter_pkg;

    typedef enum logic {MODE_WRAP, MODE_SAT} cnt_mode_e;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/counter_step.sv
// Combinational step function: next count and terminal-event flag for an enabled cycle.
module counter_step
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] limit,
    input  logic             dir,
    input  logic             mode,
    output logic [WIDTH-1:0] nxt,
    output logic             term_evt
);

    logic sat;

    assign sat = (mode == MODE_SAT);

    always_comb begin
        nxt      = out;
        term_evt = 1'b0;
        if (dir == DIR_UP) begin
            if (out < limit) begin
                nxt = out + 1'b1;
            end else begin
                // Also covers out > limit left behind by a lowered limit.
                term_evt = 1'b1;
                nxt      = sat ? limit : '0;
            end
        end else begin
            if (out > limit) begin
                nxt = limit;
            end else if (out == '0) begin
                term_evt = 1'b1;
                nxt      = sat ? '0 : limit;
            end else begin
                nxt = out - 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_mod.sv
// Parametrised up/down modulo counter with load clipping, terminal-count pulse
// and sticky overflow flag. Priority per cycle: rst > load > en > hold.
module counter_mod
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic [WIDTH-1:0] limit,
    input  logic             load,
    input  logic [WIDTH-1:0] init,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             ovf
);

    logic [WIDTH-1:0] out_q, out_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] step_nxt;
    logic             step_term;

    counter_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .out      (out_q),
        .limit    (limit),
        .dir      (dir),
        .mode     (mode),
        .nxt      (step_nxt),
        .term_evt (step_term)
    );

    always_comb begin
        out_d = out_q;
        tc_d  = 1'b0;
        ovf_d = ovf_q & ~ovf_clr;
        if (load) begin
            out_d = (init < limit) ? init : limit;
        end else if (en) begin
            out_d = step_nxt;
            tc_d  = step_term;
            // A terminal event beats a simultaneous clear.
            ovf_d = step_term | (ovf_q & ~ovf_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= RST_VAL;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            out_q <= out_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign out = out_q;
    assign tc  = tc_q;
    assign ovf = ovf_q;

endmodule
